// File: rtl/c4_pkg.sv
// Shared Connect-4 definitions: board size defaults, state and player encodings.
package c4_pkg;

    localparam int unsigned COLS_DEF = 7;
    localparam int unsigned ROWS_DEF = 6;

    // Width of column pointers and row indices.
    localparam int unsigned PW = 3;

    // One-hot state encoding; the bits drive the q_* flags directly.
    typedef enum logic [7:0] {
        StStart   = 8'b0000_0001,
        StP1Move  = 8'b0000_0010,
        StP1Place = 8'b0000_0100,
        StP1Win   = 8'b0000_1000,
        StP2Move  = 8'b0001_0000,
        StP2Place = 8'b0010_0000,
        StP2Win   = 8'b0100_0000,
        StDraw    = 8'b1000_0000
    } state_e;

    typedef enum logic {
        PlayerP1 = 1'b0,
        PlayerP2 = 1'b1
    } player_e;

endpackage

// File: rtl/c4_column_heights.sv
// Per-column fill heights plus a running count of completely filled columns.
module c4_column_heights
    import c4_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic [PW-1:0] col,
    output logic [PW-1:0] height,
    output logic          full,
    output logic [PW-1:0] full_columns
);

    logic [PW-1:0] heights_q [COLS];
    logic [PW-1:0] heights_d [COLS];
    logic [PW-1:0] full_cnt_q;
    logic [PW-1:0] full_cnt_d;

    // Select the height of the addressed column.
    always_comb begin
        height = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (col == PW'(i)) begin
                height = heights_q[i];
            end
        end
    end

    assign full         = (height == PW'(ROWS));
    assign full_columns = full_cnt_q;

    // Next heights; the full counter bumps on the same update that tops out a column.
    always_comb begin
        heights_d  = heights_q;
        full_cnt_d = full_cnt_q;
        if (clear) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                heights_d[i] = '0;
            end
            full_cnt_d = '0;
        end else if (inc && !full) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                if (col == PW'(i)) begin
                    heights_d[i] = heights_q[i] + 1'b1;
                end
            end
            if (height == PW'(ROWS - 1)) begin
                full_cnt_d = full_cnt_q + 1'b1;
            end
        end
    end

    // Height and full-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                heights_q[i] <= '0;
            end
            full_cnt_q <= '0;
        end else begin
            heights_q  <= heights_d;
            full_cnt_q <= full_cnt_d;
        end
    end

endmodule

// File: rtl/c4_turn_controller.sv
// Connect-4 turn sequencer: game FSM, column pointer, board write and win-check handshake.
module c4_turn_controller
    import c4_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start_Ack,
    input  logic          Left_b,
    input  logic          Right_b,
    input  logic          Down_b,
    input  logic          chk_done,
    input  logic          chk_win,
    output logic [PW-1:0] p_pointer,
    output logic [PW-1:0] full_columns,
    output logic          wr_en,
    output logic [PW-1:0] wr_col,
    output logic [PW-1:0] wr_row,
    output logic          wr_player,
    output logic          chk_req,
    output logic          q_start,
    output logic          q_p1_move,
    output logic          q_p1_place,
    output logic          q_p1_win,
    output logic          q_p2_move,
    output logic          q_p2_place,
    output logic          q_p2_win,
    output logic          q_draw
);

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          wr_en_q, wr_en_d;
    logic [PW-1:0] wr_col_q, wr_col_d;
    logic [PW-1:0] wr_row_q, wr_row_d;
    logic          wr_player_q, wr_player_d;
    logic          chk_req_q, chk_req_d;
    logic          clear, inc;
    logic [PW-1:0] height;
    logic          col_full;
    logic [7:0]    state_bits;

    c4_column_heights #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_heights (
        .clk          (Clk),
        .rst          (Reset),
        .clear        (clear),
        .inc          (inc),
        .col          (ptr_q),
        .height       (height),
        .full         (col_full),
        .full_columns (full_columns)
    );

    // Next-state, pointer, write and handshake logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        wr_col_d    = wr_col_q;
        wr_row_d    = wr_row_q;
        wr_player_d = wr_player_q;
        chk_req_d   = chk_req_q;
        clear       = 1'b0;
        inc         = 1'b0;
        unique case (state_q)
            StStart: begin
                if (Start_Ack) begin
                    clear   = 1'b1;
                    ptr_d   = PW'(3);
                    state_d = StP1Move;
                end
            end
            StP1Move, StP2Move: begin
                // Down_b wins over movement even when the drop is refused.
                if (Down_b) begin
                    if (!col_full) begin
                        inc         = 1'b1;
                        wr_en_d     = 1'b1;
                        wr_col_d    = ptr_q;
                        wr_row_d    = height;
                        wr_player_d = (state_q == StP2Move) ? PlayerP2 : PlayerP1;
                        state_d     = (state_q == StP1Move) ? StP1Place : StP2Place;
                    end
                end else if (Left_b && !Right_b) begin
                    if (ptr_q != '0) begin
                        ptr_d = ptr_q - 1'b1;
                    end
                end else if (Right_b && !Left_b) begin
                    if (ptr_q != PW'(COLS - 1)) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            StP1Place, StP2Place: begin
                // Request rises the cycle after the write strobe.
                if (!chk_req_q) begin
                    chk_req_d = 1'b1;
                end else if (chk_done) begin
                    chk_req_d = 1'b0;
                    if (chk_win) begin
                        state_d = (state_q == StP1Place) ? StP1Win : StP2Win;
                    end else if (full_columns == PW'(COLS)) begin
                        state_d = StDraw;
                    end else begin
                        state_d = (state_q == StP1Place) ? StP2Move : StP1Move;
                    end
                end
            end
            StP1Win, StP2Win, StDraw: begin
                if (Start_Ack) begin
                    state_d = StStart;
                end
            end
            default: state_d = StStart;
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StStart;
            ptr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_col_q    <= '0;
            wr_row_q    <= '0;
            wr_player_q <= 1'b0;
            chk_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            wr_col_q    <= wr_col_d;
            wr_row_q    <= wr_row_d;
            wr_player_q <= wr_player_d;
            chk_req_q   <= chk_req_d;
        end
    end

    assign state_bits = state_q;
    assign q_start    = state_bits[0];
    assign q_p1_move  = state_bits[1];
    assign q_p1_place = state_bits[2];
    assign q_p1_win   = state_bits[3];
    assign q_p2_move  = state_bits[4];
    assign q_p2_place = state_bits[5];
    assign q_p2_win   = state_bits[6];
    assign q_draw     = state_bits[7];

    assign p_pointer = ptr_q;
    assign wr_en     = wr_en_q;
    assign wr_col    = wr_col_q;
    assign wr_row    = wr_row_q;
    assign wr_player = wr_player_q;
    assign chk_req   = chk_req_q;

endmodule

// File: tb/tb_c4_turn_controller.sv
// Directed bench: expected board writes go into a scoreboard popped by a write monitor.
module tb_c4_turn_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start_Ack, Left_b, Right_b, Down_b, chk_done, chk_win;
    logic [2:0] p_pointer, full_columns, wr_col, wr_row;
    logic       wr_en, wr_player, chk_req;
    logic       q_start, q_p1_move, q_p1_place, q_p1_win;
    logic       q_p2_move, q_p2_place, q_p2_win, q_draw;
    logic [7:0] qv;

    localparam logic [7:0] SS  = 8'h01;
    localparam logic [7:0] P1M = 8'h02;
    localparam logic [7:0] P1P = 8'h04;
    localparam logic [7:0] P1W = 8'h08;
    localparam logic [7:0] P2M = 8'h10;
    localparam logic [7:0] P2P = 8'h20;
    localparam logic [7:0] DR  = 8'h80;

    typedef struct {
        logic [2:0] col;
        logic [2:0] row;
        logic       player;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    c4_turn_controller dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start_Ack    (Start_Ack),
        .Left_b       (Left_b),
        .Right_b      (Right_b),
        .Down_b       (Down_b),
        .chk_done     (chk_done),
        .chk_win      (chk_win),
        .p_pointer    (p_pointer),
        .full_columns (full_columns),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_player    (wr_player),
        .chk_req      (chk_req),
        .q_start      (q_start),
        .q_p1_move    (q_p1_move),
        .q_p1_place   (q_p1_place),
        .q_p1_win     (q_p1_win),
        .q_p2_move    (q_p2_move),
        .q_p2_place   (q_p2_place),
        .q_p2_win     (q_p2_win),
        .q_draw       (q_draw)
    );

    assign qv = {q_draw, q_p2_win, q_p2_place, q_p2_move, q_p1_win, q_p1_place, q_p1_move, q_start};

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every cycle with wr_en high must match the oldest expected write.
    always @(negedge Clk) begin : mon
        wr_t e;
        if (wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got wr_en=%b col=%0d row=%0d expected no write",
                         wr_en, wr_col, wr_row);
            end else begin
                e = exp_q.pop_front();
                check("wr_col", 32'(wr_col), 32'(e.col));
                check("wr_row", 32'(wr_row), 32'(e.row));
                check("wr_player", 32'(wr_player), 32'(e.player));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic l, input logic r, input logic d);
        Start_Ack = s;
        Left_b    = l;
        Right_b   = r;
        Down_b    = d;
        tick();
        Start_Ack = 1'b0;
        Left_b    = 1'b0;
        Right_b   = 1'b0;
        Down_b    = 1'b0;
    endtask

    // One complete turn: drop, optional checker delay (with ignored buttons), then result.
    task automatic drop(input int col, input int row, input int player, input int delay,
                        input logic win, input logic [7:0] next);
        wr_t w;
        w.col    = 3'(col);
        w.row    = 3'(row);
        w.player = player[0];
        exp_q.push_back(w);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("place_state", 32'(qv), 32'(player != 0 ? P2P : P1P));
        check("chk_req_first", 32'(chk_req), 32'd0);
        tick();
        check("chk_req_rise", 32'(chk_req), 32'd1);
        for (int i = 0; i < delay; i++) begin
            Right_b = 1'b1;
            Down_b  = 1'b1;
            tick();
            check("chk_req_hold", 32'(chk_req), 32'd1);
        end
        Right_b  = 1'b0;
        Down_b   = 1'b0;
        chk_done = 1'b1;
        chk_win  = win;
        tick();
        chk_done = 1'b0;
        chk_win  = 1'b0;
        check("chk_req_drop", 32'(chk_req), 32'd0);
        check("next_state", 32'(qv), 32'(next));
        check("ptr_kept", 32'(p_pointer), 32'(col));
    endtask

    initial begin
        Reset = 1'b1;
        Start_Ack = 1'b0; Left_b = 1'b0; Right_b = 1'b0; Down_b = 1'b0;
        chk_done = 1'b0; chk_win = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_state", 32'(qv), 32'(SS));
        check("rst_ptr", 32'(p_pointer), 32'd0);
        check("rst_full", 32'(full_columns), 32'd0);
        check("rst_wr", {28'd0, wr_en, wr_player, chk_req, 1'b0}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_col, wr_row}, 32'd0);
        Reset = 1'b0;
        tick();

        // START ignores everything but Start_Ack.
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        check("start_ignore", 32'(qv), 32'(SS));
        check("start_ptr", 32'(p_pointer), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("p1_move", 32'(qv), 32'(P1M));
        check("start_ptr3", 32'(p_pointer), 32'd3);
        check("start_full", 32'(full_columns), 32'd0);

        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("lr_same", 32'(p_pointer), 32'd3);
        repeat (5) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("right_sat", 32'(p_pointer), 32'd6);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("ack_in_move", 32'(qv), 32'(P1M));
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("left3", 32'(p_pointer), 32'd3);

        drop(3, 0, 0, 0, 1'b0, P2M);
        drop(3, 1, 1, 0, 1'b0, P1M);

        // Fill column 0, then try to overfill it.
        repeat (4) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("left_sat", 32'(p_pointer), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drop(0, k, k % 2, 0, 1'b0, (k % 2 == 0) ? P2M : P1M);
        end
        check("full_one", 32'(full_columns), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("full_drop_state", 32'(qv), 32'(P1M));
        check("full_drop_wr", 32'(wr_en), 32'd0);
        tick();
        check("full_drop_state2", 32'(qv), 32'(P1M));

        // Slow checker, then a win.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        drop(1, 0, 0, 10, 1'b1, P1W);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("win_to_start", 32'(qv), 32'(SS));
        check("board_kept", 32'(full_columns), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart", 32'(qv), 32'(P1M));
        check("restart_full", 32'(full_columns), 32'd0);
        check("restart_ptr", 32'(p_pointer), 32'd3);

        // Fill the whole board with no winner.
        repeat (3) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) pulse(1'b0, 1'b0, 1'b1, 1'b0);
            for (int r = 0; r < 6; r++) begin
                int k;
                k = c * 6 + r;
                drop(c, r, k % 2, 0, 1'b0, (k == 41) ? DR : ((k % 2 != 0) ? P1M : P2M));
            end
        end
        check("draw_full", 32'(full_columns), 32'd7);
        check("draw_state", 32'(q_draw), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("draw_to_start", 32'(qv), 32'(SS));

        // Reset in the middle of a handshake.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        begin
            wr_t w;
            w.col = 3'd3; w.row = 3'd0; w.player = 1'b0;
            exp_q.push_back(w);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("mid_req", 32'(chk_req), 32'd1);
        Reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(chk_req), 32'd0);
        check("mid_rst_state", 32'(qv), 32'(SS));
        #2;
        Reset = 1'b0;
        tick();
        chk_done = 1'b1;
        chk_win  = 1'b1;
        tick();
        chk_done = 1'b0;
        chk_win  = 1'b0;
        check("late_done_state", 32'(qv), 32'(SS));
        check("late_done_req", 32'(chk_req), 32'd0);
        tick();
        check("late_done_state2", 32'(qv), 32'(SS));

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c4_turn_controller.md
# c4_turn_controller

Turn-sequencing controller for the Connect-4 game datapath. It owns the game state machine, the column pointer and per-column fill heights. It issues one-cycle writes into the board store and hands each placed piece to the external win checker through a req/done handshake. Its one-hot state flags feed the seven-segment debug digits and the VGA renderer.

## Interface
- COLS, 7, number of board columns (pointer range 0..COLS-1)
- ROWS, 6, number of board rows (row 0 = bottom)
- Clk  in  1  system clock (100 MHz)
- Reset  in  1  asynchronous, active-high reset
- Start_Ack  in  1  one-cycle pulse: start a game or acknowledge game end
- Left_b, Right_b, Down_b  in  1 each  one-cycle debounced button pulses (SCEN)
- chk_done  in  1  win checker finished; valid for one cycle
- chk_win  in  1  win result, qualified by chk_done
- p_pointer  out  3  current column pointer
- full_columns  out  3  count of columns at height ROWS
- wr_en  out  1  board write strobe, one cycle
- wr_col, wr_row  out  3 each  write address
- wr_player  out  1  0 = player 1, 1 = player 2
- chk_req  out  1  win-check request, level
- q_start, q_p1_move, q_p1_place, q_p1_win, q_p2_move, q_p2_place, q_p2_win, q_draw  out  1 each  one-hot state flags

## Operation
- States: START, P1_MOVE, P1_PLACE, P1_WIN, P2_MOVE, P2_PLACE, P2_WIN, DRAW. The q_* outputs are registered and one-hot.
- Reset values:
  - State is START, so q_start=1 and all other q_* are 0.
  - p_pointer=0, full_columns=0, all heights 0.
  - wr_en=0, wr_col=0, wr_row=0, wr_player=0, chk_req=0.
- START:
  - On Start_Ack, clear all heights and full_columns, set p_pointer=3, and go to P1_MOVE.
  - All other inputs are ignored.
- Px_MOVE, pointer movement:
  - Left_b decrements p_pointer and saturates at 0.
  - Right_b increments p_pointer and saturates at COLS-1.
  - Left_b and Right_b in the same cycle: pointer unchanged.
- Px_MOVE, drop:
  - Down_b on a column with height[p_pointer] < ROWS: register wr_col=p_pointer, wr_row=height, wr_player=x-1, and set wr_en for one cycle.
  - In the same update, increment the height and go to Px_PLACE.
  - Down_b on a full column is ignored and the state stays put.
  - Down_b takes priority over Left_b/Right_b in the same cycle; the pointer does not move.
- Px_PLACE:
  - First cycle: wr_en=1 and chk_req=0.
  - From the second cycle on, chk_req=1 and is held until chk_done.
  - On chk_done, drop chk_req in the same edge, then:
    - chk_win=1: go to Px_WIN.
    - Else if full_columns==COLS: go to DRAW.
    - Else: go to the other player's MOVE with p_pointer retained.
  - chk_done outside PLACE with chk_req high is ignored.
  - Button pulses during PLACE are dropped.
- full_columns is incremented in the same edge as a height reaching ROWS. It is therefore stable before chk_req rises.
- Px_WIN / DRAW: Start_Ack goes to START. The board is cleared only on the next START→P1_MOVE.
- Start_Ack in MOVE or PLACE is ignored.
- Reset mid-handshake drops chk_req immediately. A late chk_done arriving afterwards is ignored because the state is START.

## Timing
- Down_b sampled at edge n:
  - wr_en is high during cycle n+1.
  - chk_req is high from cycle n+2.
  - The earliest next-player MOVE is 1 cycle after chk_done is sampled.
- Pointer update latency: 1 cycle after the button pulse.
- wr_* fields are stable while wr_en=1. wr_col/wr_row/wr_player hold their last values otherwise.
- All outputs are registered, with no combinational input→output paths.

## Structure
- Shared package c4_pkg holds:
  - COLS and ROWS defaults.
  - State encoding constants.
  - Player encoding (P1=0, P2=1).
  - Pointer and row width (3).
- Sub-module c4_column_heights holds the COLS×3-bit height counters and the full_columns counter. Its interface:
  - Inputs: clear, inc, col.
  - Outputs: height of the selected column, full flag, full_columns.
- The FSM and write/handshake registers stay in c4_turn_controller.

## Test plan
- Reset, then Start_Ack → q_p1_move=1, p_pointer=3, full_columns=0. Right_b ×5 → p_pointer=6 (saturates).
- P1 drop at col 3 → wr_en pulse with wr_col=3, wr_row=0, wr_player=0. Then chk_req=1; drive chk_done=1, chk_win=0 → q_p2_move=1. P2 drop at col 3 → wr_row=1, wr_player=1.
- Fill col 0 to 6 pieces by alternating players, then Down_b at col 0 → no wr_en, state unchanged, full_columns=1.
- Checker delays chk_done by 10 cycles → chk_req held 10 cycles. Then chk_win=1 → q_p1_win=1. Start_Ack → q_start=1; next Start_Ack → all heights 0.
- Fill all 42 cells with chk_win=0 → after the last chk_done, q_draw=1 and full_columns=7.
- Assert Reset while chk_req=1 → chk_req=0 and q_start=1 in the same cycle. A subsequent chk_done causes no state change.
